// File: rtl/cam_rgb565_capture.sv
// rtl/cam_rgb565_capture.sv - OV7670-style camera bus capture, RGB565 pair assembly, RGB888 expansion
module cam_rgb565_capture #(
    parameter logic [11:0] H_ACTIVE = 12'd640,
    parameter logic [11:0] V_ACTIVE = 12'd480,
    parameter logic        VS_POL   = 1'b1,
    parameter logic        HI_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cam_pclk,
    input  logic        cam_vs,
    input  logic        cam_hr,
    input  logic [7:0]  cam_dta,
    output logic        pix_valid,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        frame_done,
    output logic        line_err
);

    localparam logic [2:0] WAIT_VS   = 3'd0;
    localparam logic [2:0] WAIT_ACT  = 3'd1;
    localparam logic [2:0] LINE_IDLE = 3'd2;
    localparam logic [2:0] BYTE0     = 3'd3;
    localparam logic [2:0] BYTE1     = 3'd4;

    logic [1:0]  pclk_s;
    logic [1:0]  vs_s;
    logic [1:0]  hr_s;
    logic [7:0]  dta_s0;
    logic [7:0]  dta_s1;
    logic        pclk_prev;

    logic [2:0]  state;
    logic [11:0] x;
    logic [11:0] y;
    logic [7:0]  first;

    logic        smp;
    logic        vs_blank;
    logic        hr;
    logic [15:0] w;
    logic [11:0] x_inc;
    logic [11:0] y_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pclk_s    <= 2'b00;
            vs_s      <= 2'b00;
            hr_s      <= 2'b00;
            dta_s0    <= 8'h00;
            dta_s1    <= 8'h00;
            pclk_prev <= 1'b0;
        end else begin
            pclk_s    <= {pclk_s[0], cam_pclk};
            vs_s      <= {vs_s[0], cam_vs};
            hr_s      <= {hr_s[0], cam_hr};
            dta_s0    <= cam_dta;
            dta_s1    <= dta_s0;
            pclk_prev <= pclk_s[1];
        end
    end

    // vs/hr/data are taken from the same sync stage as pclk so a byte lines up with its strobe
    assign smp      = pclk_s[1] & ~pclk_prev;
    assign vs_blank = (vs_s[1] == VS_POL);
    assign hr       = hr_s[1];
    assign w        = HI_FIRST ? {first, dta_s1} : {dta_s1, first};
    assign x_inc    = (x == 12'hFFF) ? x : x + 12'd1;
    assign y_inc    = (y == 12'hFFF) ? y : y + 12'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_VS;
            x          <= 12'd0;
            y          <= 12'd0;
            first      <= 8'h00;
            pix_valid  <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            pix_r      <= 8'h00;
            pix_g      <= 8'h00;
            pix_b      <= 8'h00;
            pix_x      <= 12'd0;
            pix_y      <= 12'd0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                WAIT_VS: begin
                    if (vs_blank) state <= WAIT_ACT;
                end
                WAIT_ACT: begin
                    if (!vs_blank) begin
                        state    <= LINE_IDLE;
                        y        <= 12'd0;
                        line_err <= 1'b0;
                    end
                end
                LINE_IDLE, BYTE0, BYTE1: begin
                    // blanking aborts any partial pixel and wins over a coincident strobe
                    if (vs_blank) begin
                        if (y != 12'd0) frame_done <= 1'b1;
                        state <= WAIT_ACT;
                    end else if (smp) begin
                        case (state)
                            LINE_IDLE: begin
                                if (hr) begin
                                    first <= dta_s1;
                                    x     <= 12'd0;
                                    state <= BYTE1;
                                end
                            end
                            BYTE0: begin
                                if (hr) begin
                                    first <= dta_s1;
                                    state <= BYTE1;
                                end else begin
                                    if (x != H_ACTIVE) line_err <= 1'b1;
                                    y     <= y_inc;
                                    state <= LINE_IDLE;
                                end
                            end
                            default: begin
                                if (hr) begin
                                    if (x < H_ACTIVE && y < V_ACTIVE) begin
                                        pix_valid <= 1'b1;
                                        pix_sof   <= (x == 12'd0) && (y == 12'd0);
                                        pix_eol   <= (x == H_ACTIVE - 12'd1);
                                        pix_r     <= {w[15:11], w[15:13]};
                                        pix_g     <= {w[10:5], w[10:9]};
                                        pix_b     <= {w[4:0], w[4:2]};
                                        pix_x     <= x;
                                        pix_y     <= y;
                                    end
                                    x     <= x_inc;
                                    state <= BYTE0;
                                end else begin
                                    line_err <= 1'b1;
                                    y        <= y_inc;
                                    state    <= LINE_IDLE;
                                end
                            end
                        endcase
                    end
                end
                default: state <= WAIT_VS;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// tb/tb_cam_rgb565_capture.sv - directed vector bench for cam_rgb565_capture on a 4x2 frame
module tb_cam_rgb565_capture;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [11:0] x;
        logic [11:0] y;
        logic        sof;
        logic        eol;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cam_pclk;
    logic        cam_vs;
    logic        cam_hr;
    logic [7:0]  cam_dta;

    logic        pix_valid, pix_sof, pix_eol, frame_done, line_err;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [11:0] pix_x, pix_y;

    logic        lo_valid, lo_sof, lo_eol, lo_frame_done, lo_line_err;
    logic [7:0]  lo_r, lo_g, lo_b;
    logic [11:0] lo_x, lo_y;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   fd_cnt  = 0;
    pix_t q[$];
    pix_t q_lo[$];
    vec_t vt[8];

    always #5 clk = ~clk;

    cam_rgb565_capture #(
        .H_ACTIVE(12'd4), .V_ACTIVE(12'd2), .VS_POL(1'b1), .HI_FIRST(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cam_pclk(cam_pclk), .cam_vs(cam_vs),
        .cam_hr(cam_hr), .cam_dta(cam_dta), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_eol(pix_eol), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done), .line_err(line_err)
    );

    cam_rgb565_capture #(
        .H_ACTIVE(12'd4), .V_ACTIVE(12'd2), .VS_POL(1'b1), .HI_FIRST(1'b0)
    ) dut_lo (
        .clk(clk), .reset_n(reset_n), .cam_pclk(cam_pclk), .cam_vs(cam_vs),
        .cam_hr(cam_hr), .cam_dta(cam_dta), .pix_valid(lo_valid), .pix_sof(lo_sof),
        .pix_eol(lo_eol), .pix_r(lo_r), .pix_g(lo_g), .pix_b(lo_b),
        .pix_x(lo_x), .pix_y(lo_y), .frame_done(lo_frame_done), .line_err(lo_line_err)
    );

    always @(negedge clk) begin
        if (pix_valid) q.push_back('{pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol});
        if (lo_valid) q_lo.push_back('{lo_r, lo_g, lo_b, lo_x, lo_y, lo_sof, lo_eol});
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
        cam_vs  = vs;
        cam_hr  = hr;
        cam_dta = d;
        #40 cam_pclk = 1'b1;
        #40 cam_pclk = 1'b0;
    endtask

    task automatic send_px(input logic [7:0] a, input logic [7:0] b);
        cyc(1'b0, 1'b1, a);
        cyc(1'b0, 1'b1, b);
    endtask

    task automatic line_red(input int n);
        for (int i = 0; i < n; i++) send_px(8'hF8, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vblank(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_obs();
        q.delete();
        q_lo.delete();
        fd_cnt = 0;
    endtask

    initial begin
        vt[0] = '{8'h07, 8'hE0, 8'h00, 8'hFF, 8'h00};
        vt[1] = '{8'h00, 8'h1F, 8'h00, 8'h00, 8'hFF};
        vt[2] = '{8'hF8, 8'h00, 8'hFF, 8'h00, 8'h00};
        vt[3] = '{8'h12, 8'h34, 8'h10, 8'h45, 8'hA5};
        vt[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vt[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[6] = '{8'h08, 8'h21, 8'h08, 8'h04, 8'h08};
        vt[7] = '{8'hA5, 8'h5A, 8'hA5, 8'hAA, 8'hD6};

        reset_n  = 1'b0;
        cam_pclk = 1'b0;
        cam_vs   = 1'b0;
        cam_hr   = 1'b0;
        cam_dta  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst pix_valid", pix_valid, 0);
        chk("rst pix_r", pix_r, 0);
        chk("rst pix_x", pix_x, 0);
        chk("rst pix_y", pix_y, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst line_err", line_err, 0);
        reset_n = 1'b1;

        // basic 4x2 red frame
        clear_obs();
        vblank(2);
        idle(2);
        line_red(4);
        line_red(4);
        vblank(2);
        chk("f1 count", q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < q.size()) begin
                chk($sformatf("f1[%0d] r", i), q[i].r, 8'hFF);
                chk($sformatf("f1[%0d] g", i), q[i].g, 8'h00);
                chk($sformatf("f1[%0d] b", i), q[i].b, 8'h00);
                chk($sformatf("f1[%0d] x", i), q[i].x, i % 4);
                chk($sformatf("f1[%0d] y", i), q[i].y, i / 4);
                chk($sformatf("f1[%0d] sof", i), q[i].sof, (i == 0) ? 1 : 0);
                chk($sformatf("f1[%0d] eol", i), q[i].eol, (i % 4 == 3) ? 1 : 0);
            end
        end
        chk("f1 frame_done", fd_cnt, 1);
        chk("f1 line_err", line_err, 0);

        // table frame, high byte first, checked on the HI_FIRST=1 instance
        clear_obs();
        idle(2);
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 4; i++) send_px(vt[l*4+i].b0, vt[l*4+i].b1);
            cyc(1'b0, 1'b0, 8'h00);
        end
        vblank(2);
        chk("vt hi count", q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < q.size()) begin
                chk($sformatf("vt hi[%0d] r", i), q[i].r, vt[i].r);
                chk($sformatf("vt hi[%0d] g", i), q[i].g, vt[i].g);
                chk($sformatf("vt hi[%0d] b", i), q[i].b, vt[i].b);
            end
        end

        // same table, low byte first, checked on the HI_FIRST=0 instance
        clear_obs();
        idle(2);
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 4; i++) send_px(vt[l*4+i].b1, vt[l*4+i].b0);
            cyc(1'b0, 1'b0, 8'h00);
        end
        vblank(2);
        chk("vt lo count", q_lo.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < q_lo.size()) begin
                chk($sformatf("vt lo[%0d] r", i), q_lo[i].r, vt[i].r);
                chk($sformatf("vt lo[%0d] g", i), q_lo[i].g, vt[i].g);
                chk($sformatf("vt lo[%0d] b", i), q_lo[i].b, vt[i].b);
            end
        end
        chk("vt lo line_err", lo_line_err, 0);

        // odd byte count line: 7 bytes
        clear_obs();
        idle(2);
        for (int i = 0; i < 3; i++) send_px(8'hF8, 8'h00);
        cyc(1'b0, 1'b1, 8'hF8);
        cyc(1'b0, 1'b0, 8'h00);
        idle(1);
        chk("odd count", q.size(), 3);
        chk("odd line_err", line_err, 1);
        line_red(4);
        vblank(2);
        chk("odd err sticky", line_err, 1);
        idle(2);
        chk("odd err cleared", line_err, 0);

        // overlong line: 6 pixels into H_ACTIVE=4
        clear_obs();
        for (int i = 0; i < 6; i++) send_px(8'hF8, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        idle(1);
        chk("long count", q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < q.size()) chk($sformatf("long[%0d] x", i), q[i].x, i);
        chk("long line_err", line_err, 1);
        vblank(2);

        // vs asserted mid-pair
        idle(2);
        clear_obs();
        line_red(4);
        cyc(1'b0, 1'b1, 8'hF8);
        vblank(2);
        chk("abort count", q.size(), 4);
        chk("abort frame_done", fd_cnt, 1);
        clear_obs();
        idle(2);
        for (int i = 0; i < 4; i++) send_px(8'h07, 8'hE0);
        cyc(1'b0, 1'b0, 8'h00);
        idle(1);
        chk("after abort count", q.size(), 4);
        if (q.size() > 0) begin
            chk("after abort x", q[0].x, 0);
            chk("after abort y", q[0].y, 0);
            chk("after abort sof", q[0].sof, 1);
            chk("after abort g", q[0].g, 8'hFF);
        end
        vblank(2);

        // reset pulsed mid-line
        idle(2);
        send_px(8'hF8, 8'h00);
        cyc(1'b0, 1'b1, 8'hF8);
        chk("pre-reset pix_r", pix_r, 8'hFF);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid-reset pix_r", pix_r, 0);
        chk("mid-reset pix_valid", pix_valid, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clear_obs();
        cyc(1'b0, 1'b1, 8'h00);
        send_px(8'hF8, 8'h00);
        send_px(8'hF8, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        line_red(4);
        chk("post-reset no pixels", q.size(), 0);
        vblank(2);
        idle(2);
        line_red(4);
        idle(1);
        chk("post-reset frame count", q.size(), 4);
        if (q.size() > 0) chk("post-reset sof", q[0].sof, 1);
        vblank(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_rgb565_capture.md
# cam_rgb565_capture

Camera capture front end feeding the HDMI video pattern/output stage. Samples an 8-bit OV7670-style camera bus (cam_pclk, cam_hr, cam_vs, cam_dta) into the system clock domain, assembles byte pairs into RGB565 pixels, and expands them to RGB888. Produces a single-cycle pixel strobe with x/y coordinates and frame/line markers for the downstream display stage.

## Interface
- H_ACTIVE, 12'd640: active pixels per line
- V_ACTIVE, 12'd480: active lines per frame
- VS_POL, 1'b1: cam_vs level that means vertical blanking (1 = active-high)
- HI_FIRST, 1'b1: 1 = first byte of a pair is RGB565[15:8]; 0 = first byte is [7:0]

- clk  in  1  system clock; must be at least 4x cam_pclk
- reset_n  in  1  asynchronous active-low reset
- cam_pclk  in  1  camera pixel clock, asynchronous to clk
- cam_vs  in  1  camera vertical sync
- cam_hr  in  1  camera HREF, high during active bytes
- cam_dta  in  8  camera data byte
- pix_valid  out  1  one-clk strobe: pix_r/g/b, pix_x, pix_y valid
- pix_sof  out  1  with pix_valid on pixel (0,0)
- pix_eol  out  1  with pix_valid on pixel x = H_ACTIVE-1
- pix_r, pix_g, pix_b  out  8 each  RGB888 pixel
- pix_x, pix_y  out  12 each  pixel coordinates
- frame_done  out  1  one-clk pulse at start of vertical blanking after a frame with ≥1 line
- line_err  out  1  sticky; set on malformed line, cleared at next frame start

## Operation
- Synchronizer: cam_pclk, cam_vs, cam_hr, cam_dta each pass through 2 flops on clk. Rising edge of synchronized pclk (sync[1] & ~prev) = sample strobe smp; cam_vs/cam_hr/cam_dta taken from the same sync stage.
- vs_blank = (sync cam_vs == VS_POL).
- FSM states: WAIT_VS (reset state), WAIT_ACT, LINE_IDLE, BYTE0, BYTE1.
  - WAIT_VS: stay until vs_blank = 1 (aligns to a frame boundary after reset).
  - WAIT_ACT: on vs_blank falling -> LINE_IDLE; y <= 0, line_err <= 0.
  - LINE_IDLE: on smp with cam_hr = 1 -> latch byte as first byte, go BYTE1; x <= 0.
  - BYTE1: on smp with cam_hr = 1 -> form pixel, emit if x < H_ACTIVE and y < V_ACTIVE, x <= x+1, go BYTE0. On smp with cam_hr = 0 -> odd byte count, set line_err, y <= y+1, go LINE_IDLE.
  - BYTE0: on smp with cam_hr = 1 -> latch first byte, go BYTE1. On smp with cam_hr = 0 -> line end; if x != H_ACTIVE set line_err; y <= y+1; go LINE_IDLE.
  - Any of LINE_IDLE/BYTE0/BYTE1 with vs_blank = 1 -> abort partial pixel, pulse frame_done if y > 0, go WAIT_ACT. vs_blank has priority over smp in the same cycle.
- Pixel assembly: w = HI_FIRST ? {first, second} : {second, first}; r5 = w[15:11], g6 = w[10:5], b5 = w[4:0].
- Expansion: pix_r = {r5, r5[4:2]}, pix_g = {g6, g6[5:4]}, pix_b = {b5, b5[4:2]}.
- x > H_ACTIVE-1: pixels dropped, x keeps counting (saturates at 12'hFFF), line_err set at line end. y ≥ V_ACTIVE: pixels dropped, no error.
- pix_sof = (x == 0 && y == 0); pix_eol = (x == H_ACTIVE-1).

## Timing
- Reset: all outputs 0; x, y 0; FSM WAIT_VS; sync flops 0.
- Latency: cam_pclk rising edge of second byte -> pix_valid high ≤ 4 clk (2 sync + 1 edge detect + 1 output reg); ±1 clk jitter from asynchronous sampling.
- pix_valid, pix_sof, pix_eol, frame_done are single-clk pulses; data/coordinate outputs hold until the next pix_valid.
- Reset deassertion mid-frame: no pixel output until a full vs_blank high→low sequence is seen.
- cam_hr and cam_vs transitions are acted on only at smp except vs_blank abort, which is evaluated every clk.

## Test plan
- Reset then one 4x2 frame (H_ACTIVE=4, V_ACTIVE=2), bytes 0xF8,0x00 repeated -> 8 pix_valid, each pix_r=0xFF, pix_g=0x00, pix_b=0x00; pix_sof on (0,0), pix_eol at x=3; frame_done once; line_err 0.
- Pair 0x07,0xE0 then 0x00,0x1F with HI_FIRST=1 -> (0x00,0xFF,0x00) then (0x00,0x00,0xFF); HI_FIRST=0 with 0xE0,0x07 -> (0x00,0xFF,0x00).
- Line of 7 bytes -> 3 pixels, line_err=1 after HREF falls; cleared at next frame start.
- Line of 6 pixels with H_ACTIVE=4 -> only x=0..3 emitted, line_err=1.
- cam_vs asserted mid-line after first byte -> no pixel for the partial pair, frame_done pulse, next frame starts at (0,0).
- reset_n pulsed low mid-line -> outputs 0 immediately; bytes until next vs_blank fall produce no pix_valid.
